mips32_fetch_unit: RTL and testbench
====================================

MIPS32_FETCH_UNIT -- requirements
Module: mips32_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: instruction buffer entries and maximum of (buffered + outstanding) requests.
REQ-002 Parameter RESET_PC, default 32'h0: word address fetched first after reset.
REQ-003 clk1  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  word address of request.
REQ-008 imem_rsp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  taken branch from EX/MEM; flush and refetch.
REQ-011 redirect_pc  input  32  branch target word address.
REQ-012 if_valid  output  1  if_ir/if_npc hold a valid instruction.
REQ-013 if_ready  input  1  decode stage consumes the instruction.
REQ-014 if_ir  output  32  instruction word (IF_ID_IR).
REQ-015 if_npc  output  32  fetch address + 1 (IF_ID_NPC).
REQ-016 fetch_halted  output  1  HLT enqueued; no further requests.

Function
REQ-017 Fetch PC is word-addressed; each accepted request (imem_req_valid & imem_req_ready) advances the PC by 1.
REQ-018 imem_req_valid SHALL be 1 only when not halted, redirect_valid is 0, and buffered + outstanding < DEPTH.
REQ-019 Each accepted response SHALL be enqueued with npc = its request address + 1, unless marked for drop.
REQ-020 if_valid = buffer not empty; if_ir/if_npc = head entry; the head is dequeued when if_valid & if_ready.
REQ-021 Enqueue and dequeue in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-022 Buffer full with if_ready=0 SHALL hold the head stable and issue no requests; no response is ever lost.
REQ-023 On redirect_valid, the next edge SHALL empty the buffer, set PC = redirect_pc, clear the halted flag, and mark all outstanding requests (including one accepted that cycle) for drop.
REQ-024 A response arriving in the redirect cycle SHALL be discarded; a dequeue in that cycle SHALL still count as consumed.
REQ-025 A dropped response SHALL decrement the drop count, not enter the buffer; the first request to redirect_pc issues no earlier than the cycle after the redirect.
REQ-026 An enqueued word with opcode [31:26] = 6'b111111 SHALL set fetch_halted on that edge; responses to requests outstanding behind it SHALL be dropped.
REQ-027 Outstanding count width SHALL cover 0..DEPTH with no wrap; buffer pointers wrap modulo DEPTH.

Reset
REQ-028 While rst_n = 0: PC = RESET_PC, buffer empty, outstanding = 0, drop count = 0, fetch_halted = 0, imem_req_valid = 0, if_valid = 0, if_ir = 0, if_npc = 0.
REQ-029 Reset asserted mid-operation SHALL abandon in-flight requests; the memory model is reset by the same rst_n.
REQ-030 The first request SHALL issue in the first cycle after rst_n deasserts, at address RESET_PC.

Structure
REQ-031 Opcode constants (HLT, BEQZ, BNEQZ, ...) and the 32-bit word width SHALL live in the shared package mips32_pkg.
REQ-032 The instruction buffer SHALL be sub-module mips32_fetch_fifo (DEPTH x 64 bits: ir, npc; push/pop/full/empty/count).

Verification
REQ-033 Zero-wait memory, if_ready = 1, Mem[0..3] = 32'h28010078, 32'h0c631800, 32'h20220000, HLT -> four instructions delivered in order with npc 1, 2, 3, 4; fetch_halted = 1; no request to address 4.
REQ-034 if_ready = 0 for 10 cycles -> exactly DEPTH = 4 requests issued (addresses 0-3); if_ir stays 32'h28010078; release drains all four in order.
REQ-035 Redirect to 32'h20 while 2 requests are outstanding and 2 entries are buffered -> both late responses dropped; next if_ir from address 32'h20 with npc 32'h21.
REQ-036 Redirect in the same cycle as imem_rsp_valid and an if_ready handshake -> the dequeued instruction is counted once, the response is discarded, and the buffer is empty on the next cycle.
REQ-037 HLT at address 5 on a wrong path, then redirect to 32'h8 -> fetch_halted clears and fetching resumes at 32'h8.
REQ-038 rst_n pulsed low mid-stream with 3 requests outstanding -> all outputs at reset values immediately; the next request is at RESET_PC.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: word width, opcode encodings and the fetch buffer entry.
package mips32_pkg;
  localparam int WORD_W = 32;
  localparam int OPC_W  = 6;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  typedef struct packed {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] npc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return (word[WORD_W-1 -: OPC_W] == OP_HLT);
  endfunction
endpackage

// File: rtl/mips32_fetch_fifo.sv
// Instruction buffer: DEPTH entries of {ir, npc}, pointers wrap modulo DEPTH.
module mips32_fetch_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     din,
  input  logic             pop,
  output fetch_entry_t     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (flush) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // State registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign count = count_q;
endmodule

// File: rtl/mips32_fetch_unit.sv
// MIPS32 IF stage: word-addressed PC, in-order memory requests bounded by DEPTH,
// instruction buffer towards decode, redirect flush and HLT stop.
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WORD_W-1:0] if_ir,
  output logic [WORD_W-1:0] if_npc,
  output logic              fetch_halted
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              halted_q, halted_d;

  logic [CNT_W-1:0]  buf_count_s;
  logic              buf_full_s, buf_empty_s;
  logic [CNT_W:0]    inflight_s;
  logic              req_fire_s, rsp_take_s, rsp_keep_s, rsp_halt_s, pop_s;
  fetch_entry_t      push_entry_s, head_entry_s;

  // Request gating, response classification and next-state.
  always_comb begin
    rsp_take_s = imem_rsp_valid && (outst_q != CNT_W'(0));
    rsp_keep_s = rsp_take_s && (drop_q == CNT_W'(0)) && !redirect_valid;
    rsp_halt_s = rsp_keep_s && is_halt(imem_rsp_data);
    inflight_s = {1'b0, buf_count_s} + {1'b0, outst_q};
    // A HLT arriving now already stops the next request, so nothing past it is fetched.
    imem_req_valid = rst_n && !halted_q && !redirect_valid && !rsp_halt_s &&
                     !buf_full_s && (inflight_s < DEPTH_LIM);
    req_fire_s = imem_req_valid && imem_req_ready;
    pop_s      = !buf_empty_s && if_ready;

    // Oldest outstanding request is pc_q - outst_q whenever nothing is pending drop.
    push_entry_s.ir  = imem_rsp_data;
    push_entry_s.npc = pc_q - WORD_W'(outst_q) + 32'd1;

    outst_d  = outst_q + CNT_W'(req_fire_s) - CNT_W'(rsp_take_s);
    pc_d     = pc_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      drop_d   = outst_d;
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + 32'd1;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_take_s && (drop_q != CNT_W'(0))) begin
        drop_d = drop_q - CNT_W'(1);
      end else if (rsp_halt_s) begin
        halted_d = 1'b1;
        drop_d   = outst_d;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      outst_q  <= CNT_W'(0);
      drop_q   <= CNT_W'(0);
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
    end
  end

  mips32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk1  (clk1),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (rsp_keep_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_entry_s),
    .full  (buf_full_s),
    .empty (buf_empty_s),
    .count (buf_count_s)
  );

  assign imem_req_addr = pc_q;
  assign if_valid      = !buf_empty_s;
  assign if_ir         = head_entry_s.ir;
  assign if_npc        = head_entry_s.npc;
  assign fetch_halted  = halted_q;
endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Scoreboard bench: expected instruction streams are derived from memory contents and
// program order; a monitor compares every request address and every consumed instruction.
module tb_mips32_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HLT_W    = 32'hfc000000;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid, if_ready;
  logic [31:0] if_ir, if_npc;
  logic        fetch_halted;

  typedef struct { logic [31:0] ir; logic [31:0] npc; } exp_t;
  exp_t        exp_q[$];
  exp_t        pend_q[$];
  logic [31:0] exp_req_pc, pend_pc;
  logic [31:0] inflight[$];
  logic [31:0] mem [256];

  int checks = 0, failures = 0, req_cnt = 0, deliv_cnt = 0;
  bit rand_mode = 1'b0, rsp_en = 1'b1, req_ready_en = 1'b1;

  mips32_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_ir(if_ir), .if_npc(if_npc),
    .fetch_halted(fetch_halted)
  );

  initial forever #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input bit halt);
    logic [31:0] w;
    w = $urandom;
    if (halt) w[31:26] = 6'h3f;
    else if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
    return w;
  endfunction

  task automatic fill_mem(input int halt_1_in);
    for (int i = 0; i < 256; i++)
      mem[i] = mk_word((halt_1_in > 0) && ($urandom_range(0, halt_1_in - 1) == 0));
  endtask

  // Program order from a start address up to and including the first HLT.
  task automatic build_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_t e;
    pend_q.delete();
    pend_pc = start;
    a = start;
    for (int i = 0; i < 300; i++) begin
      e.ir  = mem[a[7:0]];
      e.npc = a + 32'd1;
      pend_q.push_back(e);
      if (e.ir[31:26] == 6'h3f) break;
      a = a + 32'd1;
    end
  endtask

  // Memory model: in-order responses, first one presented the cycle after acceptance.
  initial begin
    logic        acc, taken;
    logic [31:0] acc_addr, head;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk1);
      acc      = rst_n && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      taken    = rst_n && imem_rsp_valid;
      @(posedge clk1); #1;
      if (!rst_n) begin
        inflight.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (taken) void'(inflight.pop_front());
        if (acc) inflight.push_back(acc_addr);
        if (inflight.size() > 0 && rsp_en && (!rand_mode || $urandom_range(0, 2) != 0)) begin
          head = inflight[0];
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem[head[7:0]];
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
      imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : req_ready_en;
    end
  end

  // Monitor: request addresses, request gating and consumed instructions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk1);
      if (!rst_n) begin
        exp_q      = pend_q;
        exp_req_pc = pend_pc;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_req_pc);
          exp_req_pc = exp_req_pc + 32'd1;
          req_cnt++;
        end
        if (redirect_valid || fetch_halted) chk("req_gate", 32'(imem_req_valid), 32'd0);
        if (if_valid && if_ready) begin
          deliv_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_deliv actual_npc=%h expected=none", if_npc);
          end else begin
            e = exp_q.pop_front();
            chk("if_ir", if_ir, e.ir);
            chk("if_npc", if_npc, e.npc);
            if (e.ir[31:26] == 6'h3f) chk("halt_flag", 32'(fetch_halted), 32'd1);
          end
        end
        if (redirect_valid) begin
          exp_q      = pend_q;
          exp_req_pc = pend_pc;
        end
      end
    end
  end

  task automatic assert_reset();
    build_stream(RESET_PC);
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_ir", if_ir, 32'd0);
    chk("rst_if_npc", if_npc, 32'd0);
    chk("rst_halted", 32'(fetch_halted), 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk1);
    #2;
    rst_n = 1'b1;
    @(negedge clk1);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    @(posedge clk1); #2;
  endtask

  task automatic do_reset();
    @(posedge clk1); #2;
    assert_reset();
    release_reset();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk1);
    #2;
  endtask

  task automatic redirect(input logic [31:0] pc);
    build_stream(pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    @(posedge clk1); #2;
    redirect_valid = 1'b0;
  endtask

  task automatic load_program();
    fill_mem(0);
    mem[0] = 32'h28010078;
    mem[1] = 32'h0c631800;
    mem[2] = 32'h20220000;
    mem[3] = HLT_W;
  endtask

  initial begin
    int r0, d0, n;
    if_ready = 1'b1;

    // Zero-wait program run ending in HLT.
    load_program();
    r0 = req_cnt; d0 = deliv_cnt;
    do_reset();
    cycles(20);
    chk("t33_deliv", 32'(deliv_cnt - d0), 32'd4);
    chk("t33_reqs", 32'(req_cnt - r0), 32'd4);
    chk("t33_halted", 32'(fetch_halted), 32'd1);
    chk("t33_left", 32'(exp_q.size()), 32'd0);

    // Decode stall: buffer fills to DEPTH and the head holds.
    if_ready = 1'b0;
    r0 = req_cnt; d0 = deliv_cnt;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (i >= 1) chk("t34_head", if_ir, 32'h28010078);
    end
    chk("t34_reqs", 32'(req_cnt - r0), 32'(DEPTH));
    chk("t34_valid", 32'(if_valid), 32'd1);
    if_ready = 1'b1;
    cycles(8);
    chk("t34_deliv", 32'(deliv_cnt - d0), 32'd4);
    chk("t34_left", 32'(exp_q.size()), 32'd0);

    // Redirect with two responses buffered and two outstanding.
    fill_mem(0);
    mem[8'h23] = HLT_W;
    if_ready = 1'b0; rsp_en = 1'b0;
    r0 = req_cnt;
    do_reset();
    for (int i = 0; i < 20 && (req_cnt - r0) < 4; i++) cycles(1);
    chk("t35_reqs", 32'(req_cnt - r0), 32'd4);
    rsp_en = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk1);
      if (imem_rsp_valid) n++;
      if (n == 2) rsp_en = 1'b0;
    end
    chk("t35_rsps", 32'(n), 32'd2);
    cycles(1);
    chk("t35_buffered", 32'(if_valid), 32'd1);
    redirect(32'h20);
    chk("t35_flushed", 32'(if_valid), 32'd0);
    rsp_en = 1'b1; if_ready = 1'b1;
    cycles(15);
    chk("t35_left", 32'(exp_q.size()), 32'd0);

    // Redirect coinciding with a response and a decode handshake.
    fill_mem(0);
    mem[8'h43] = HLT_W;
    do_reset();
    cycles(5);
    chk("t36_pre_rsp", 32'(imem_rsp_valid), 32'd1);
    chk("t36_pre_valid", 32'(if_valid), 32'd1);
    d0 = deliv_cnt;
    redirect(32'h40);
    chk("t36_empty", 32'(if_valid), 32'd0);
    chk("t36_once", 32'(deliv_cnt - d0), 32'd1);
    cycles(12);
    chk("t36_left", 32'(exp_q.size()), 32'd0);

    // HLT on a wrong path, then redirect away from it.
    fill_mem(0);
    mem[5]  = HLT_W;
    mem[11] = HLT_W;
    do_reset();
    for (int i = 0; i < 30 && !fetch_halted; i++) cycles(1);
    chk("t37_halted", 32'(fetch_halted), 32'd1);
    cycles(3);
    chk("t37_no_req", 32'(imem_req_valid), 32'd0);
    redirect(32'h8);
    chk("t37_resumed", 32'(fetch_halted), 32'd0);
    cycles(15);
    chk("t37_left", 32'(exp_q.size()), 32'd0);
    chk("t37_halted2", 32'(fetch_halted), 32'd1);

    // Reset with three requests in flight.
    fill_mem(0);
    if_ready = 1'b0; rsp_en = 1'b0; req_ready_en = 1'b1;
    r0 = req_cnt;
    do_reset();
    n = 1;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk1);
      if (imem_req_valid && imem_req_ready) n++;
      if (n == 3) req_ready_en = 1'b0;
    end
    cycles(2);
    chk("t38_reqs", 32'(req_cnt - r0), 32'd3);
    chk("t38_pre_reqv", 32'(imem_req_valid), 32'd1);
    assert_reset();
    req_ready_en = 1'b1; rsp_en = 1'b1; if_ready = 1'b1;
    release_reset();
    cycles(10);

    // Randomised traffic with redirects and occasional resets.
    rand_mode = 1'b1;
    fill_mem(12);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      redirect_valid = 1'b0;
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 24) == 0) begin
          build_stream(32'($urandom_range(0, 255)));
          redirect_pc    = pend_pc;
          redirect_valid = 1'b1;
        end
        cycles(1);
      end
    end
    redirect_valid = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
